// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings (decode, IF/ID, IM, CP0).
interface fetch_stage_if;
    logic        enable;
    logic        req;
    logic        eret;
    logic [31:0] epc_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        d_is_jump_i;
    logic [31:0] im_rdata_i;
    logic [31:0] i_addr_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [4:0]  e_code_o;
    logic        bd_o;
    logic [31:0] fetch_cnt_o;

    modport master (
        input  enable, req, eret, epc_i, br_taken_i, br_target_i, d_is_jump_i, im_rdata_i,
        output i_addr_o, instr_o, pc_o, pc4_o, e_code_o, bd_o, fetch_cnt_o
    );

    modport slave (
        output enable, req, eret, epc_i, br_taken_i, br_target_i, d_is_jump_i, im_rdata_i,
        input  i_addr_o, instr_o, pc_o, pc4_o, e_code_o, bd_o, fetch_cnt_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, stalled-redirect capture
// and fetch address checking.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master fif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        addr_err;

    always_comb begin
        pc_d        = pc_q;
        pend_vld_d  = pend_vld_q;
        pend_tgt_d  = pend_tgt_q;
        fetch_cnt_d = fetch_cnt_q;

        if (fif.req) begin
            pc_d       = HANDLER_PC;
            pend_vld_d = 1'b0;
        end else if (fif.eret) begin
            pc_d       = fif.epc_i;
            pend_vld_d = 1'b0;
        end else if (fif.enable && fif.br_taken_i) begin
            pc_d       = fif.br_target_i;
            pend_vld_d = 1'b0;
        end else if (fif.enable && pend_vld_q) begin
            pc_d       = pend_tgt_q;
            pend_vld_d = 1'b0;
        end else if (fif.enable) begin
            pc_d = pc_q + 32'd4;
        end

        // A branch resolved while stalled must not be lost; replay it on the next advance.
        if (!fif.enable && fif.br_taken_i && !fif.req && !fif.eret) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = fif.br_target_i;
        end

        if (fif.enable && !fif.req && !fif.eret) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            pend_vld_q  <= 1'b0;
            pend_tgt_q  <= 32'd0;
            fetch_cnt_q <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            pend_vld_q  <= pend_vld_d;
            pend_tgt_q  <= pend_tgt_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign addr_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

    always_comb begin
        fif.i_addr_o    = pc_q;
        fif.pc_o        = pc_q;
        fif.pc4_o       = pc_q + 32'd4;
        fif.bd_o        = fif.d_is_jump_i;
        fif.fetch_cnt_o = fetch_cnt_q;
        fif.instr_o     = fif.im_rdata_i;
        fif.e_code_o    = 5'd0;
        // Bad fetch address: tag AdEL and hand a nop downstream.
        if (addr_err) begin
            fif.instr_o  = 32'd0;
            fif.e_code_o = 5'd4;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (F) stage of the 5-stage pipeline. Sits directly upstream of the IF/ID register and feeds it `instr_o`, `pc4_o`, `e_code_o` and `bd_o`.
- Owns the PC register and drives the instruction-memory address.
- Selects the next PC from four sources: sequential, branch/jump redirect, exception entry, and eret return.
- Detects fetch address errors and tags the instruction with an exception code and a branch-delay flag.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry PC.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = advance PC; 0 = stall (hold PC).
- req  in  1  exception/interrupt taken this cycle; redirect to HANDLER_PC.
- eret  in  1  eret in D; redirect to epc_i.
- epc_i  in  32  return address for eret.
- br_taken_i  in  1  branch/jump in D resolved taken.
- br_target_i  in  32  branch/jump target.
- d_is_jump_i  in  1  instruction currently in D is a branch/jump.
- im_rdata_i  in  32  instruction word read from IM at `i_addr_o` (combinational IM).
- i_addr_o  out  32  IM address; equals PC.
- instr_o  out  32  fetched instruction to IF/ID.
- pc_o  out  32  current PC.
- pc4_o  out  32  PC+4 to IF/ID.
- e_code_o  out  5  fetch exception code; 0 = none, 4 = AdEL.
- bd_o  out  1  fetched instruction is a branch-delay slot.
- fetch_cnt_o  out  32  count of accepted fetches.

Behaviour:
- Reset (asynchronous, immediate):
  - PC = RESET_PC; pend_vld = 0; pend_tgt = 0; fetch_cnt = 0.
  - Resulting outputs: `i_addr_o`/`pc_o` = 0x3000, `pc4_o` = 0x3004, `instr_o` = `im_rdata_i`, `e_code_o` = 0, `bd_o` = `d_is_jump_i`.
- Reset asserted mid-operation discards any pending redirect and count.
- Next-PC priority at each rising edge, highest first:
  1. req: PC <= HANDLER_PC. Clears pend_vld. Applies regardless of enable.
  2. eret: PC <= epc_i. Clears pend_vld. Applies regardless of enable.
  3. enable && br_taken_i: PC <= br_target_i. Clears pend_vld.
  4. enable && pend_vld: PC <= pend_tgt. Clears pend_vld.
  5. enable: PC <= PC + 4 (32-bit wrap; no carry out).
  6. otherwise: hold PC.
- Pending redirect:
  - When !enable && br_taken_i && !req && !eret: pend_vld <= 1 and pend_tgt <= br_target_i.
  - A later capture while pend_vld = 1 overwrites pend_tgt.
  - The pending target is consumed on the first enabled edge.
- Address check (combinational on PC): error = (PC[1:0] != 0) || PC < IM_LO || PC > IM_HI.
  - error = 1: `e_code_o` = 5'd4, `instr_o` = 0 (nop).
  - error = 0: `e_code_o` = 0, `instr_o` = `im_rdata_i`.
  - A misaligned PC after an eret is checked the same way.
- `pc4_o` = PC + 4, combinational, wraps at 32 bits.
- `bd_o` = `d_is_jump_i`, combinational.
- Fetch counter: fetch_cnt increments by 1 on each edge where enable && !req && !eret. It wraps at 2^32.
- No state changes other than those listed. No internal flush; the IF/ID register handles flush.

Test Plan:
- Reset then 3 enabled cycles -> `pc_o` 0x3000, 0x3004, 0x3008, 0x300C; `fetch_cnt_o` = 3; `e_code_o` = 0.
- At PC = 0x3010 assert br_taken_i = 1 with br_target_i = 0x3100 and enable = 1 -> next `pc_o` = 0x3100. With d_is_jump_i = 1 in the slot cycle, `bd_o` = 1.
- enable = 0 with br_taken_i pulse to 0x3200, then enable = 1 for 2 cycles -> PC holds, then 0x3200, then 0x3204; pend_vld cleared.
- req = 1 with enable = 0 at PC = 0x3020 -> next `pc_o` = 0x4180, `pc4_o` = 0x4184; pending redirect discarded.
- req and eret asserted together (epc_i = 0x3040) -> PC = 0x4180. Next cycle eret alone -> PC = 0x3040.
- eret with epc_i = 0x3042 -> `e_code_o` = 4 and `instr_o` = 0. Then br to 0x7000 -> `e_code_o` = 4. Asserting reset mid-cycle -> PC = 0x3000 immediately.
